// File: rtl/fx2_fifo_master.sv
// FX2 slave-FIFO bus master. Moves command bytes out of EP2 and writes reply
// bytes (EP8) and bulk data bytes (EP6) into the FX2, with a one-cycle address
// turnaround before every bus state and a bounded burst length per grant.
module fx2_fifo_master #(
    parameter int MAX_BURST = 16
) (
    input  logic       ifclk,
    input  logic       reset_n,
    inout  wire  [7:0] fd,
    output logic       slrd,
    output logic       slwr,
    output logic       sloe,
    output logic [1:0] fifoadr,
    output logic       pktend,
    input  logic [2:0] flags,
    output logic [7:0] cmd_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    input  logic [7:0] reply_data,
    input  logic       reply_valid,
    output logic       reply_ready,
    input  logic       reply_end,
    input  logic [7:0] data_data,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       data_flush
);

    typedef enum logic [2:0] {
        IDLE,
        CMD_RD,
        REPLY_WR,
        DATA_WR,
        PKTEND,
        TURN
    } state_t;

    localparam logic [1:0] ADR_EP2 = 2'b00;
    localparam logic [1:0] ADR_EP6 = 2'b10;
    localparam logic [1:0] ADR_EP8 = 2'b11;
    localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

    state_t     state_q, state_d;
    state_t     tgt_q, tgt_d;
    logic [1:0] adr_q, adr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cmd_data_q;
    logic       cmd_valid_q;
    logic [7:0] fd_out;
    logic       fd_oe;
    logic       burst_end;

    assign fifoadr   = adr_q;
    assign cmd_data  = cmd_data_q;
    assign cmd_valid = cmd_valid_q;
    assign fd        = fd_oe ? fd_out : 8'hzz;
    assign burst_end = (cnt_q == LAST_CNT);

    // Arbitration, burst control and strobe generation; TURN always hands over to tgt_q
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        adr_d       = adr_q;
        cnt_d       = cnt_q;
        slrd        = 1'b1;
        slwr        = 1'b1;
        sloe        = 1'b1;
        pktend      = 1'b1;
        reply_ready = 1'b0;
        data_ready  = 1'b0;
        fd_out      = 8'h00;
        fd_oe       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (flags[0]) begin
                    adr_d   = ADR_EP2;
                    tgt_d   = CMD_RD;
                    state_d = TURN;
                end else if (reply_valid && flags[2]) begin
                    adr_d   = ADR_EP8;
                    tgt_d   = REPLY_WR;
                    state_d = TURN;
                end else if ((data_valid || data_flush) && flags[1]) begin
                    adr_d   = ADR_EP6;
                    tgt_d   = DATA_WR;
                    state_d = TURN;
                end
            end
            TURN: begin
                state_d = tgt_q;
            end
            CMD_RD: begin
                sloe = 1'b0;
                tgt_d = IDLE;
                if (flags[0] && (!cmd_valid_q || cmd_ready)) begin
                    slrd  = 1'b0;
                    cnt_d = cnt_q + 8'd1;
                    if (burst_end) begin
                        state_d = TURN;
                    end
                end else begin
                    state_d = TURN;
                end
            end
            REPLY_WR: begin
                fd_oe  = 1'b1;
                fd_out = reply_data;
                tgt_d  = IDLE;
                if (reply_valid && flags[2]) begin
                    slwr        = 1'b0;
                    reply_ready = 1'b1;
                    cnt_d       = cnt_q + 8'd1;
                    if (reply_end) begin
                        state_d = PKTEND;
                    end else if (burst_end) begin
                        state_d = TURN;
                    end
                end else begin
                    state_d = TURN;
                end
            end
            DATA_WR: begin
                fd_oe  = 1'b1;
                fd_out = data_data;
                tgt_d  = IDLE;
                if (data_valid && flags[1]) begin
                    slwr       = 1'b0;
                    data_ready = 1'b1;
                    cnt_d      = cnt_q + 8'd1;
                    if (data_flush) begin
                        state_d = PKTEND;
                    end else if (burst_end) begin
                        state_d = TURN;
                    end
                end else if (data_flush) begin
                    state_d = PKTEND;
                end else begin
                    state_d = TURN;
                end
            end
            PKTEND: begin
                pktend  = 1'b0;
                tgt_d   = IDLE;
                state_d = TURN;
            end
            default: begin
                state_d = IDLE;
                tgt_d   = IDLE;
            end
        endcase
    end

    // State, turnaround target, endpoint address and burst counter registers
    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tgt_q   <= IDLE;
            adr_q   <= ADR_EP2;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Command output register: capture on every read strobe, drop once consumed
    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_data_q  <= 8'h00;
            cmd_valid_q <= 1'b0;
        end else if (!slrd) begin
            cmd_data_q  <= fd;
            cmd_valid_q <= 1'b1;
        end else if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fx2_fifo_master.sv
// Testbench for fx2_fifo_master: a cycle table for reply/data/pktend sequencing,
// then an FX2 FIFO model for command reads, data bursts, arbitration and reset.
module tb_fx2_fifo_master;

    logic       ifclk = 1'b0;
    logic       reset_n = 1'b0;
    wire  [7:0] fd;
    logic       host_oe = 1'b0;
    logic [7:0] host_byte = 8'h00;
    logic       slrd, slwr, sloe, pktend;
    logic [1:0] fifoadr;
    logic [2:0] flags = 3'b000;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [7:0] reply_data = 8'h00;
    logic       reply_valid = 1'b0;
    logic       reply_ready;
    logic       reply_end = 1'b0;
    logic [7:0] data_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       data_flush = 1'b0;

    int vec_count = 0;
    int err_count = 0;

    assign fd = host_oe ? host_byte : 8'hzz;

    fx2_fifo_master #(.MAX_BURST(16)) dut (
        .ifclk       (ifclk),
        .reset_n     (reset_n),
        .fd          (fd),
        .slrd        (slrd),
        .slwr        (slwr),
        .sloe        (sloe),
        .fifoadr     (fifoadr),
        .pktend      (pktend),
        .flags       (flags),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .reply_data  (reply_data),
        .reply_valid (reply_valid),
        .reply_ready (reply_ready),
        .reply_end   (reply_end),
        .data_data   (data_data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data_flush  (data_flush)
    );

    // Free-running interface clock, 10 time units per period
    always #5 ifclk = ~ifclk;

    typedef struct {
        logic [2:0] flags;
        logic       rv;
        logic       re;
        logic [7:0] rd;
        logic       dv;
        logic       df;
        logic [7:0] dd;
        logic [1:0] adr;
        logic       slwr;
        logic       pktend;
        logic       rr;
        logic       dr;
        logic       fd_chk;
        logic [7:0] fd;
    } vec_t;

    vec_t vecs[32];

    // FX2 and source/sink model state
    logic [7:0] ep2_mem[16];
    int ep2_wr, ep2_rd;
    logic [7:0] ep6_log[64];
    int ep6_cnt;
    int data_idx, data_len;
    logic ep6_space, cmd_rdy_ctl;
    logic [7:0] cmd_log[16];
    int cmd_cnt, rd_cycles, first_rd_cyc, cyc;
    int bursts[8];
    int burst_start[8];
    int burst_cnt, run_len;
    logic last_rd, last_wr6, last_dr;
    logic [7:0] last_fd;

    function automatic vec_t mk(input logic [2:0] f, input logic rv, input logic re,
                                input logic [7:0] rd, input logic dv, input logic df,
                                input logic [7:0] dd, input logic [1:0] adr, input logic wr,
                                input logic pe, input logic rr, input logic dr,
                                input logic fc, input logic [7:0] fdv);
        vec_t v;
        v.flags = f; v.rv = rv; v.re = re; v.rd = rd; v.dv = dv; v.df = df; v.dd = dd;
        v.adr = adr; v.slwr = wr; v.pktend = pe; v.rr = rr; v.dr = dr;
        v.fd_chk = fc; v.fd = fdv;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge ifclk);
        flags       = v.flags;
        reply_valid = v.rv;
        reply_end   = v.re;
        reply_data  = v.rd;
        data_valid  = v.dv;
        data_flush  = v.df;
        data_data   = v.dd;
        cmd_ready   = 1'b0;
        host_oe     = 1'b0;
    endtask

    task automatic resetModel();
        ep2_wr = 0; ep2_rd = 0; ep6_cnt = 0; data_idx = 0; data_len = 0;
        ep6_space = 1'b1; cmd_rdy_ctl = 1'b0; cmd_cnt = 0; rd_cycles = 0;
        first_rd_cyc = -1; cyc = 0; burst_cnt = 0; run_len = 0;
        last_rd = 1'b0; last_wr6 = 1'b0; last_dr = 1'b0; last_fd = 8'h00;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        flags = 3'b000; reply_valid = 1'b0; reply_end = 1'b0; data_valid = 1'b0;
        data_flush = 1'b0; cmd_ready = 1'b0; host_oe = 1'b0;
        resetModel();
        repeat (2) @(negedge ifclk);
        reset_n = 1'b1;
    endtask

    // One model cycle: commit last edge's transfers, drive inputs, sample strobes
    task automatic modelCycle();
        @(negedge ifclk);
        cyc++;
        if (last_rd) ep2_rd++;
        if (last_wr6 && ep6_cnt < 64) begin
            ep6_log[ep6_cnt] = last_fd;
            ep6_cnt++;
        end
        if (last_dr) data_idx++;
        flags       = {1'b1, ep6_space, (ep2_rd < ep2_wr)};
        data_valid  = (data_idx < data_len);
        data_data   = 8'(data_idx);
        data_flush  = 1'b0;
        reply_valid = 1'b0;
        reply_end   = 1'b0;
        cmd_ready   = cmd_rdy_ctl;
        host_oe     = !sloe && (ep2_rd < ep2_wr);
        host_byte   = ep2_mem[ep2_rd % 16];
        #1;
        last_rd  = !slrd;
        last_wr6 = !slwr && (fifoadr == 2'b10);
        last_dr  = data_ready;
        last_fd  = fd;
        if (cmd_valid && cmd_ready && cmd_cnt < 16) begin
            cmd_log[cmd_cnt] = cmd_data;
            cmd_cnt++;
        end
        if (!slrd) begin
            rd_cycles++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            checkOutput("slrd_adr", 32'(fifoadr), 32'd0);
        end
        checkOutput("strobe_excl", 32'(!slrd && !slwr), 32'd0);
        if (last_wr6) begin
            if (run_len == 0 && burst_cnt < 8) burst_start[burst_cnt] = cyc;
            run_len++;
        end else if (run_len != 0) begin
            if (burst_cnt < 8) bursts[burst_cnt] = run_len;
            burst_cnt++;
            run_len = 0;
        end
    endtask

    task automatic runModel(input int n, input int stop_at, input int inject_at);
        bit injected = 0;
        for (int i = 0; i < n; i++) begin
            modelCycle();
            if (inject_at >= 0 && !injected && ep6_cnt >= inject_at) begin
                ep2_mem[ep2_wr] = 8'hC5;
                ep2_wr++;
                cmd_rdy_ctl = 1'b1;
                injected = 1;
            end
            if (stop_at > 0 && ep6_cnt >= stop_at) break;
        end
    endtask

    task automatic checkEp6(input string tag);
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (ep6_log[i] !== 8'(i)) bad++;
        end
        checkOutput({tag, "_ep6_count"}, 32'(ep6_cnt), 32'd40);
        checkOutput({tag, "_ep6_order"}, 32'(bad), 32'd0);
    endtask

    initial begin
        // Reply packet 55,AA with pktend, data byte then flush, flush with a byte,
        // arbitration priority, source-idle and flag-drop exits
        vecs[0]  = mk(3'b000,0,0,8'h00,0,0,8'h00, 2'b00,1,1,0,0, 0,8'h00);
        vecs[1]  = mk(3'b100,1,0,8'h55,0,0,8'h00, 2'b00,1,1,0,0, 0,8'h00);
        vecs[2]  = mk(3'b100,1,0,8'h55,0,0,8'h00, 2'b11,1,1,0,0, 0,8'h00);
        vecs[3]  = mk(3'b100,1,0,8'h55,0,0,8'h00, 2'b11,0,1,1,0, 1,8'h55);
        vecs[4]  = mk(3'b100,1,1,8'hAA,0,0,8'h00, 2'b11,0,1,1,0, 1,8'hAA);
        vecs[5]  = mk(3'b100,0,0,8'h00,0,0,8'h00, 2'b11,1,0,0,0, 0,8'h00);
        vecs[6]  = mk(3'b100,0,0,8'h00,0,0,8'h00, 2'b11,1,1,0,0, 0,8'h00);
        vecs[7]  = mk(3'b000,0,0,8'h00,0,0,8'h00, 2'b11,1,1,0,0, 0,8'h00);
        vecs[8]  = mk(3'b010,0,0,8'h00,1,0,8'h07, 2'b11,1,1,0,0, 0,8'h00);
        vecs[9]  = mk(3'b010,0,0,8'h00,1,0,8'h07, 2'b10,1,1,0,0, 0,8'h00);
        vecs[10] = mk(3'b010,0,0,8'h00,1,0,8'h07, 2'b10,0,1,0,1, 1,8'h07);
        vecs[11] = mk(3'b010,0,0,8'h00,0,1,8'h00, 2'b10,1,1,0,0, 1,8'h00);
        vecs[12] = mk(3'b010,0,0,8'h00,0,0,8'h00, 2'b10,1,0,0,0, 0,8'h00);
        vecs[13] = mk(3'b000,0,0,8'h00,0,0,8'h00, 2'b10,1,1,0,0, 0,8'h00);
        vecs[14] = mk(3'b000,0,0,8'h00,0,0,8'h00, 2'b10,1,1,0,0, 0,8'h00);
        vecs[15] = mk(3'b010,0,0,8'h00,1,1,8'h3C, 2'b10,1,1,0,0, 0,8'h00);
        vecs[16] = mk(3'b010,0,0,8'h00,1,1,8'h3C, 2'b10,1,1,0,0, 0,8'h00);
        vecs[17] = mk(3'b010,0,0,8'h00,1,1,8'h3C, 2'b10,0,1,0,1, 1,8'h3C);
        vecs[18] = mk(3'b010,0,0,8'h00,0,0,8'h00, 2'b10,1,0,0,0, 0,8'h00);
        vecs[19] = mk(3'b000,0,0,8'h00,0,0,8'h00, 2'b10,1,1,0,0, 0,8'h00);
        vecs[20] = mk(3'b000,0,0,8'h00,0,0,8'h00, 2'b10,1,1,0,0, 0,8'h00);
        vecs[21] = mk(3'b110,1,0,8'h12,1,0,8'h34, 2'b10,1,1,0,0, 0,8'h00);
        vecs[22] = mk(3'b000,0,0,8'h00,0,0,8'h00, 2'b11,1,1,0,0, 0,8'h00);
        vecs[23] = mk(3'b000,0,0,8'h00,0,0,8'h00, 2'b11,1,1,0,0, 1,8'h00);
        vecs[24] = mk(3'b000,0,0,8'h00,0,0,8'h00, 2'b11,1,1,0,0, 0,8'h00);
        vecs[25] = mk(3'b000,0,0,8'h00,0,0,8'h00, 2'b11,1,1,0,0, 0,8'h00);
        vecs[26] = mk(3'b100,1,0,8'h77,0,0,8'h00, 2'b11,1,1,0,0, 0,8'h00);
        vecs[27] = mk(3'b000,1,0,8'h77,0,0,8'h00, 2'b11,1,1,0,0, 0,8'h00);
        vecs[28] = mk(3'b000,1,0,8'h77,0,0,8'h00, 2'b11,1,1,0,0, 1,8'h77);
        vecs[29] = mk(3'b000,0,0,8'h00,0,0,8'h00, 2'b11,1,1,0,0, 0,8'h00);
        vecs[30] = mk(3'b000,0,0,8'h00,0,0,8'h00, 2'b11,1,1,0,0, 0,8'h00);
        vecs[31] = mk(3'b000,0,0,8'h00,0,0,8'h00, 2'b11,1,1,0,0, 0,8'h00);

        $display("[TB] reset state");
        reset_n = 1'b0;
        flags = 3'b111; reply_valid = 1'b1; data_valid = 1'b1;
        repeat (2) @(negedge ifclk);
        #1;
        checkOutput("reset_strobes", {28'd0, slrd, slwr, sloe, pktend}, 32'hF);
        checkOutput("reset_adr", 32'(fifoadr), 32'd0);
        checkOutput("reset_hs", {29'd0, cmd_valid, reply_ready, data_ready}, 32'd0);
        doReset();

        $display("[TB] table vectors");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d", i),
                {20'd0, slrd, sloe, slwr, pktend, fifoadr, reply_ready, data_ready,
                 (vecs[i].fd_chk ? fd : 8'h00)},
                {20'd0, 1'b1, 1'b1, vecs[i].slwr, vecs[i].pktend, vecs[i].adr,
                 vecs[i].rr, vecs[i].dr, vecs[i].fd});
        end

        $display("[TB] command read A1 A2 A3");
        doReset();
        ep2_mem[0] = 8'hA1; ep2_mem[1] = 8'hA2; ep2_mem[2] = 8'hA3; ep2_wr = 3;
        cmd_rdy_ctl = 1'b1;
        runModel(20, 0, -1);
        checkOutput("cmdA_reads", 32'(rd_cycles), 32'd3);
        checkOutput("cmdA_count", 32'(cmd_cnt), 32'd3);
        checkOutput("cmdA_bytes", {8'd0, cmd_log[0], cmd_log[1], cmd_log[2]}, 32'h00A1A2A3);

        $display("[TB] command backpressure");
        doReset();
        ep2_mem[0] = 8'hB1; ep2_mem[1] = 8'hB2; ep2_wr = 2;
        runModel(20, 0, -1);
        checkOutput("cmdB_held_reads", 32'(rd_cycles), 32'd1);
        checkOutput("cmdB_held", {23'd0, cmd_valid, cmd_data}, 32'h1B1);
        cmd_rdy_ctl = 1'b1;
        runModel(20, 0, -1);
        checkOutput("cmdB_reads", 32'(rd_cycles), 32'd2);
        checkOutput("cmdB_bytes", {16'd0, cmd_log[0], cmd_log[1]}, 32'h0000B1B2);
        checkOutput("cmdB_count", 32'(cmd_cnt), 32'd2);

        $display("[TB] data bursts of 40 bytes");
        doReset();
        data_len = 40;
        runModel(120, 0, -1);
        checkEp6("burst");
        checkOutput("burst_cnt", 32'(burst_cnt), 32'd3);
        checkOutput("burst_lens", {8'd0, 8'(bursts[0]), 8'(bursts[1]), 8'(bursts[2])}, 32'h00101008);
        checkOutput("burst_gap1", 32'(burst_start[1] - burst_start[0]), 32'd19);
        checkOutput("burst_gap2", 32'(burst_start[2] - burst_start[1]), 32'd19);

        $display("[TB] command during data burst");
        doReset();
        data_len = 40;
        runModel(140, 0, 5);
        checkEp6("arb");
        checkOutput("arb_lens", {8'd0, 8'(bursts[0]), 8'(bursts[1]), 8'(bursts[2])}, 32'h00101008);
        checkOutput("arb_cmd", {23'd0, cmd_cnt == 1, cmd_log[0]}, 32'h1C5);
        checkOutput("arb_order", 32'(first_rd_cyc > burst_start[0] + 15 &&
                                     first_rd_cyc < burst_start[1]), 32'd1);

        $display("[TB] reset mid burst");
        doReset();
        data_len = 40;
        runModel(60, 5, -1);
        checkOutput("rst_stop_reached", 32'(ep6_cnt >= 5), 32'd1);
        #1;
        reset_n = 1'b0;
        last_rd = 1'b0; last_wr6 = 1'b0; last_dr = 1'b0;
        run_len = 0; burst_cnt = 0;
        #1;
        checkOutput("rst_async", {25'd0, slrd, slwr, sloe, pktend, fifoadr == 2'b00,
                                  reply_ready, data_ready}, 32'h7C);
        repeat (2) @(negedge ifclk);
        reset_n = 1'b1;
        runModel(120, 0, -1);
        checkEp6("rst");
        checkOutput("rst_lens", {8'd0, 8'(bursts[0]), 8'(bursts[1]), 8'(bursts[2])}, 32'h00101003);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/fx2_fifo_master.md
FX2_FIFO_MASTER -- requirements
Module: fx2_fifo_master

Interface
REQ-001 Parameter MAX_BURST, default 16, max bytes moved per grant before re-arbitration (range 1..255).
REQ-002 ifclk  input  1  FX2 interface clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 fd  inout  8  FX2 FIFO data bus; driven only while sloe=1 and state is a write state, else hi-Z.
REQ-005 slrd  output  1  FX2 read strobe, active-low.
REQ-006 slwr  output  1  FX2 write strobe, active-low.
REQ-007 sloe  output  1  FX2 output enable, active-low.
REQ-008 fifoadr  output  2  endpoint select: 00 EP2 command-out, 10 EP6 data-in, 11 EP8 reply-in.
REQ-009 pktend  output  1  FX2 packet end, active-low.
REQ-010 flags  input  3  [0] EP2 not-empty, [1] EP6 not-full, [2] EP8 not-full; active-high.
REQ-011 cmd_data / cmd_valid / cmd_ready  output 8 / output 1 / input 1  command bytes to FPGA logic.
REQ-012 reply_data / reply_valid / reply_ready / reply_end  input 8 / input 1 / output 1 / input 1  reply bytes to host; reply_end marks last byte of a packet.
REQ-013 data_data / data_valid / data_ready / data_flush  input 8 / input 1 / output 1 / input 1  bulk data bytes to host; data_flush requests short-packet commit.

Function
REQ-014 States SHALL be IDLE, CMD_RD, REPLY_WR, DATA_WR, PKTEND, TURN.
REQ-015 IDLE arbitration priority: flags[0] -> CMD_RD; else reply_valid&flags[2] -> REPLY_WR; else (data_valid|data_flush)&flags[1] -> DATA_WR; else stay.
REQ-016 Entering any bus state SHALL first set fifoadr for one cycle in TURN with all strobes high and fd hi-Z.
REQ-017 CMD_RD: fifoadr=00, sloe=0; slrd=0 in a cycle only when flags[0]=1 and output register is empty or cmd_ready=1.
REQ-018 On each edge with slrd=0, fd SHALL be captured into cmd_data and cmd_valid set next cycle; cmd_valid clears on cmd_ready with no new capture.
REQ-019 REPLY_WR: fifoadr=11, sloe=1, fd=reply_data; slwr=0 and reply_ready=1 combinationally when reply_valid=1 and flags[2]=1.
REQ-020 DATA_WR: fifoadr=10, same rule as REQ-019 with data_* and flags[1].
REQ-021 A write accepted with reply_end=1 SHALL move to PKTEND; pktend=0 for exactly one cycle with fifoadr=11, slwr=1.
REQ-022 data_flush=1 with data_valid=0 in DATA_WR SHALL produce one PKTEND cycle on fifoadr=10; data_flush with data_valid=1 writes the byte first.
REQ-023 8-bit burst counter SHALL increment per strobe; at MAX_BURST, or flag deasserted, or source idle, return to IDLE via TURN.
REQ-024 A pending cmd_valid SHALL NOT block leaving CMD_RD; the held byte stays valid until cmd_ready.
REQ-025 slrd and slwr SHALL never be low in the same cycle; fd SHALL never be driven while sloe=0.
REQ-026 Byte order per endpoint SHALL be preserved; no byte dropped or duplicated.

Reset
REQ-027 While reset_n=0: state IDLE, slrd=slwr=sloe=pktend=1, fifoadr=00, fd hi-Z, cmd_valid=0, reply_ready=data_ready=0, counter=0.
REQ-028 Reset asserted mid-burst SHALL abort immediately; any captured, unconsumed cmd byte is discarded.
REQ-029 Outputs SHALL change only on ifclk edges after reset_n deassertion.

Verification
REQ-030 Host commits 3 cmd bytes A1 A2 A3, cmd_ready=1 -> slrd low 3 cycles on fifoadr=00, cmd_data A1,A2,A3 in order, then IDLE.
REQ-031 reply bytes 55,AA with reply_end on AA -> two slwr pulses on fifoadr=11, then one pktend pulse, reply_ready high exactly twice.
REQ-032 data_valid held with 40 bytes 00..27, MAX_BURST=16 -> bursts of 16,16,8 separated by TURN cycles, EP6 file contents 00..27.
REQ-033 cmd arrives during data burst -> current burst ends at MAX_BURST, CMD_RD served before resuming data.
REQ-034 cmd_ready=0 with 2 cmd bytes pending -> one byte captured, slrd stays high until cmd_ready, no loss.
REQ-035 reset_n pulsed low mid data burst -> strobes high and fd hi-Z asynchronously, clean restart from IDLE.
